// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, default latencies, FSM states.
// MDU_MADD_EN adds the multiply-accumulate ops (7-10) to the multiply class.
package mdu_pkg;

    localparam int unsigned MDU_OP_W = 4;

    localparam logic [MDU_OP_W-1:0] MDU_NONE  = 4'd0;
    localparam logic [MDU_OP_W-1:0] MDU_MULT  = 4'd1;
    localparam logic [MDU_OP_W-1:0] MDU_MULTU = 4'd2;
    localparam logic [MDU_OP_W-1:0] MDU_DIV   = 4'd3;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 4'd4;
    localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 4'd5;
    localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 4'd6;
    localparam logic [MDU_OP_W-1:0] MDU_MADD  = 4'd7;
    localparam logic [MDU_OP_W-1:0] MDU_MADDU = 4'd8;
    localparam logic [MDU_OP_W-1:0] MDU_MSUB  = 4'd9;
    localparam logic [MDU_OP_W-1:0] MDU_MSUBU = 4'd10;

    localparam int unsigned MDU_DEF_MULT_CYCLES = 5;
    localparam int unsigned MDU_DEF_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } mdu_state_t;

    function automatic logic op_is_mul(input logic [MDU_OP_W-1:0] op);
        case (op)
            MDU_MULT, MDU_MULTU: return 1'b1;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_div(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational result datapath: product, quotient/remainder and accumulate from captured operands.
// MDU_MADD_EN enables the {HI,LO} +/- product paths.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [MDU_OP_W-1:0] op,
    input  logic [31:0]         a,
    input  logic [31:0]         b,
    input  logic [31:0]         hi,
    input  logic [31:0]         lo,
    output logic [31:0]         res_hi,
    output logic [31:0]         res_lo
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] acc;
    logic [63:0] res;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] div_s;
    logic [31:0] div_u;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;

    always_comb begin
        // Low 64 bits of the sign-extended product equal the signed product.
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'd0, a} * {32'd0, b};
        acc    = {hi, lo};

        a_mag = a[31] ? (~a + 32'd1) : a;
        b_mag = b[31] ? (~b + 32'd1) : b;
        div_s = (b == '0) ? 32'd1 : b_mag;
        div_u = (b == '0) ? 32'd1 : b;

        q_mag = a_mag / div_s;
        r_mag = a_mag % div_s;
        q_s   = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s   = a[31] ? (~r_mag + 32'd1) : r_mag;
        q_u   = a / div_u;
        r_u   = a % div_u;

        // Default keeps HI/LO, which also covers divide by zero.
        res = acc;
        case (op)
            MDU_MULT:  res = prod_s;
            MDU_MULTU: res = prod_u;
            MDU_DIV:   if (b != '0) res = {r_s, q_s};
            MDU_DIVU:  if (b != '0) res = {r_u, q_u};
`ifdef MDU_MADD_EN
            MDU_MADD:  res = acc + prod_s;
            MDU_MADDU: res = acc + prod_u;
            MDU_MSUB:  res = acc - prod_s;
            MDU_MSUBU: res = acc - prod_u;
`endif
            default:   res = acc;
        endcase

        res_hi = res[63:32];
        res_lo = res[31:0];
    end

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with HI/LO registers: FSM, latency counter, operand capture and HI/LO state.
// MDU_MADD_EN (see mdu_pkg/mdu_calc) adds MADD/MADDU/MSUB/MSUBU.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MDU_DEF_DIV_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [MDU_OP_W-1:0] op,
    input  logic [31:0]         rs_val,
    input  logic [31:0]         rt_val,
    output logic                busy,
    output logic [31:0]         hi,
    output logic [31:0]         lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    mdu_state_t          state;
    mdu_state_t          state_next;
    logic [CNT_W-1:0]    cnt;
    logic [MDU_OP_W-1:0] op_q;
    logic [31:0]         a_q;
    logic [31:0]         b_q;
    logic                accept;
    logic                accept_mul;
    logic                accept_div;
    logic                done;
    logic [31:0]         calc_hi;
    logic [31:0]         calc_lo;

    always_comb begin
        accept     = start && (state == ST_IDLE);
        accept_mul = accept && op_is_mul(op);
        accept_div = accept && op_is_div(op);
        done       = (state == ST_BUSY) && (cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept_mul || accept_div) state_next = ST_BUSY;
            ST_BUSY: if (cnt == '0) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept_mul) begin
            cnt <= MULT_LOAD;
        end else if (accept_div) begin
            cnt <= DIV_LOAD;
        end else if ((state == ST_BUSY) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= MDU_NONE;
            a_q  <= '0;
            b_q  <= '0;
        end else if (accept_mul || accept_div) begin
            op_q <= op;
            a_q  <= rs_val;
            b_q  <= rt_val;
        end
    end

    mdu_calc u_calc (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .hi     (hi),
        .lo     (lo),
        .res_hi (calc_hi),
        .res_lo (calc_lo)
    );

    // MTHI/MTLO can only be accepted in IDLE, so they never collide with a completion write.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (done) begin
            hi <= calc_hi;
            lo <= calc_lo;
        end else if (accept && (op == MDU_MTHI)) begin
            hi <= rs_val;
        end else if (accept && (op == MDU_MTLO)) begin
            lo <= rs_val;
        end
    end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Multiply/divide unit with architectural HI/LO registers for the MIPS datapath. Sits directly downstream of the register file: consumes its two read ports (rs, rt values) in the execute stage, runs multi-cycle MULT/DIV operations, and holds results in HI/LO for MFHI/MFLO. Exposes `busy` so the hazard unit can stall dependent instructions.

## Interface
- `MULT_CYCLES`, default 5: busy duration for multiply-class ops (must be ≥1).
- `DIV_CYCLES`, default 10: busy duration for divide-class ops (must be ≥1).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request strobe; qualifies `op` for one cycle.
- `op`  in  4  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11–15 reserved.
- `rs_val`  in  32  operand A (GRF read port 1).
- `rt_val`  in  32  operand B (GRF read port 2).
- `busy`  out  1  operation in flight.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, BUSY. Cycle counter width `$clog2(max(MULT_CYCLES,DIV_CYCLES)+1)`.
- Accept: `start && !busy` at a rising edge. `start` while busy is ignored entirely (no state change). Reserved op or NONE: ignored.
- MTHI/MTLO: HI or LO <= `rs_val` at accepting edge; no BUSY entry.
- MULT/MULTU: {HI,LO} <= signed/unsigned 32×32→64 product.
- MADD/MADDU: {HI,LO} <= {HI,LO} + product; MSUB/MSUBU: {HI,LO} <= {HI,LO} − product; 64-bit wrap, no overflow flag. Accumulate base is HI/LO at completion edge.
- DIV/DIVU: LO <= quotient, HI <= remainder; signed: quotient truncates toward zero, remainder takes dividend sign.
- Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Divide by zero: HI/LO unchanged at completion; busy timing unchanged.
- Operands and op are captured at the accepting edge; later `rs_val`/`rt_val` changes have no effect.
- Mult/div accept: IDLE→BUSY, counter <= N−1 (N per class). BUSY: counter decrements; at edge where counter==0 → HI/LO written, state→IDLE.

## Timing
- Reset: `busy`=0, `hi`=0, `lo`=0, state IDLE, counter 0. Reset mid-operation aborts; no HI/LO write.
- `start` sampled at edge k → `busy`=1 from after edge k until edge k+N; HI/LO visible after edge k+N, same edge `busy` falls. Busy high exactly N cycles.
- New `start` accepted at edge k+N+... i.e. first edge where `busy`=0 is sampled; back-to-back accept at edge k+N is not possible (busy still 1 when sampled).
- MTHI/MTLO: result visible one cycle after accepting edge; `busy` stays 0.
- Hazard unit must stall MF*/MT*/mult/div when `start || busy`.

## Configuration
- `MDU_MADD_EN`: defined → ops 7–10 implemented as above. Undefined → ops 7–10 treated as reserved (ignored, no busy), accumulate adder omitted.

## Structure
- Package `mdu_pkg`: op encoding localparams (`MDU_NONE`…`MDU_MSUBU`), op width, default cycle counts.
- One sub-module `mdu_calc`: combinational 64-bit product / quotient-remainder / accumulate from captured operands, op, and current HI/LO; top holds FSM, counter, operand registers, HI/LO.

## Test plan
- Reset then idle → hi=0, lo=0, busy=0; MTHI 0x1234 → hi=0x00001234 next cycle, busy never high.
- MULT rs=0xFFFFFFFE (−2), rt=3 → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same → hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=−7 (0xFFFFFFF9), rt=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 → hi/lo unchanged, busy 10 cycles.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MULT accepted, second `start` MULTU 2×2 during busy, and rs_val changed mid-op → only first result written; rst asserted on cycle 3 of a DIV → busy=0, hi=lo=0 next cycle.
- With `MDU_MADD_EN`: hi=0, lo=0xFFFFFFFF, MADDU 1×1 → hi=1, lo=0; MSUB 1×1 → hi=0, lo=0xFFFFFFFF. Without: op 8 → no busy, HI/LO unchanged.
